// File: rtl/vmicro16_uart_tx_fifo_apb_if.sv
// APB slave-side bundle for the UART TX FIFO peripheral; signal names match the
// original flat port list so the bus fabric connects unchanged.
interface vmicro16_uart_tx_fifo_apb_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
);
  logic [BUS_WIDTH-1:0]  S_PADDR;
  logic                  S_PWRITE;
  logic                  S_PSELx;
  logic                  S_PENABLE;
  logic [DATA_WIDTH-1:0] S_PWDATA;
  logic [DATA_WIDTH-1:0] S_PRDATA;
  logic                  S_PREADY;

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY
  );

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY
  );
endinterface

// File: rtl/vmicro16_uart_tx_fifo_apb.sv
// APB-programmed UART transmitter: bytes pushed through TXDATA are queued in a
// circular FIFO and drained by an 8N1 serializer onto tx_wire.
module vmicro16_uart_tx_fifo_apb #(
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKDIV_RESET = 434
) (
  input  logic                         clk,
  input  logic                         reset,
  vmicro16_uart_tx_fifo_apb_if.slave   apb,
  output logic                         tx_wire
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      clkdiv_q, clkdiv_d;

  state_t           state_q;
  logic [15:0]      timer_q, div_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_q;
  logic             tx_q;

  logic             acc, wr, push_req, push, pop, full, empty, busy, timer_done;
  logic [1:0]       addr;
  logic [15:0]      div_eff, rdata16;
  logic [7:0]       head;
  logic             unused_addr;

  assign unused_addr = ^apb.S_PADDR[BUS_WIDTH-1:2];

  assign acc        = apb.S_PSELx & apb.S_PENABLE;
  assign wr         = acc & apb.S_PWRITE;
  assign addr       = apb.S_PADDR[1:0];
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign busy       = (state_q != S_IDLE);
  assign head       = mem_q[rptr_q];
  assign div_eff    = (clkdiv_q == '0) ? 16'd1 : clkdiv_q;
  assign timer_done = (timer_q == div_q - 16'd1);

  assign push_req = wr && (addr == 2'd0);
  assign push     = push_req && !full;
  // Pop decision lives here so the FIFO pointers and the FSM see the same edge.
  assign pop      = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && timer_done));

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    clkdiv_d = clkdiv_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr && addr == 2'd1)      ovf_d = 1'b0;
    else if (push_req && full)   ovf_d = 1'b1;
    if (wr && addr == 2'd2)      clkdiv_d = 16'(apb.S_PWDATA);
  end

  always_comb begin
    rdata16 = '0;
    if (acc) begin
      case (addr)
        2'd1:    rdata16 = {8'(count_q), 4'b0000, ovf_q, busy, empty, full};
        2'd2:    rdata16 = clkdiv_q;
        default: rdata16 = '0;
      endcase
    end
  end

  assign apb.S_PRDATA = DATA_WIDTH'(rdata16);
  assign apb.S_PREADY = acc;
  assign tx_wire      = tx_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= apb.S_PWDATA[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      clkdiv_q <= 16'(CLKDIV_RESET);
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      clkdiv_q <= clkdiv_d;
    end
  end

  // tx_q is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      div_q   <= 16'd1;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= head;
            div_q   <= div_eff;
            timer_q <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (timer_done) begin
            timer_q <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_DATA: begin
          if (timer_done) begin
            timer_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_STOP: begin
          if (timer_done) begin
            timer_q <= '0;
            if (pop) begin
              shift_q <= head;
              div_q   <= div_eff;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vmicro16_uart_tx_fifo_apb.sv
// Bench for the APB UART TX FIFO: register vectors from a table, serial frames
// decoded by a monitor and matched against a byte scoreboard.
module tb_vmicro16_uart_tx_fifo_apb;
  logic clk = 1'b0;
  logic reset;
  logic tx_wire;

  vmicro16_uart_tx_fifo_apb_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) bus ();

  vmicro16_uart_tx_fifo_apb #(
    .BUS_WIDTH(16), .DATA_WIDTH(16), .FIFO_DEPTH(8), .CLKDIV_RESET(434)
  ) dut (
    .clk(clk), .reset(reset), .apb(bus.slave), .tx_wire(tx_wire)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One APB transfer; called just after a rising edge, returns just after the access edge.
  task automatic apb_xfer(input logic [1:0] a, input logic w, input logic [15:0] wd,
                          output logic [15:0] rd);
    bus.S_PADDR   = {14'd0, a};
    bus.S_PWRITE  = w;
    bus.S_PWDATA  = wd;
    bus.S_PSELx   = 1'b1;
    bus.S_PENABLE = 1'b0;
    @(negedge clk);
    check("pready_setup", {63'd0, bus.S_PREADY}, 64'd0);
    check("prdata_setup", {48'd0, bus.S_PRDATA}, 64'd0);
    @(posedge clk); #1;
    bus.S_PENABLE = 1'b1;
    @(negedge clk);
    check("pready_access", {63'd0, bus.S_PREADY}, 64'd1);
    rd = bus.S_PRDATA;
    @(posedge clk); #1;
    bus.S_PSELx   = 1'b0;
    bus.S_PENABLE = 1'b0;
    bus.S_PWRITE  = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, input logic [15:0] exp, input string name);
    logic [15:0] rd;
    apb_xfer(a, 1'b0, 16'd0, rd);
    check(name, {48'd0, rd}, {48'd0, exp});
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] wd);
    logic [15:0] rd;
    apb_xfer(a, 1'b1, wd, rd);
  endtask

  logic [7:0] sb[$];

  task automatic push_byte(input logic [7:0] b, input bit track);
    if (track) sb.push_back(b);
    reg_write(2'd0, {8'h00, b});
  endtask

  // Expected line level k clocks after the pop edge for one frame of byte b.
  function automatic logic frame_level(input logic [7:0] b, input int div, input int k);
    logic [9:0] fb;
    fb = {1'b1, b, 1'b0};
    return fb[k / div];
  endfunction

  // Serial monitor: detects a start bit and samples each bit mid-cell.
  bit         mon_en  = 1'b0;
  int         mon_div = 4;
  logic [7:0] mon_byte;
  logic       mon_start, mon_stop;
  logic [7:0] mon_exp;

  always begin
    @(negedge clk);
    if (mon_en && reset === 1'b0 && tx_wire === 1'b0) begin
      repeat (mon_div / 2) @(negedge clk);
      mon_start = tx_wire;
      for (int i = 0; i < 8; i++) begin
        repeat (mon_div) @(negedge clk);
        mon_byte[i] = tx_wire;
      end
      repeat (mon_div) @(negedge clk);
      mon_stop = tx_wire;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_unexpected actual=%0h required=none", mon_byte);
      end else begin
        mon_exp = sb.pop_front();
        check("frame_data", {56'd0, mon_byte}, {56'd0, mon_exp});
        check("frame_start_stop", {62'd0, mon_start, mon_stop}, 64'd1);
      end
    end
  end

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic set_vec(input int i, input logic [1:0] a, input logic w, input logic [15:0] wd,
                         input logic c, input logic [15:0] e, input string n);
    vecs[i].addr  = a;
    vecs[i].wr    = w;
    vecs[i].wdata = wd;
    vecs[i].chk   = c;
    vecs[i].exp   = e;
    vecs[i].name  = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [63:0] cap, expw;
    bit          all_high;

    set_vec(0,  2'd1, 1'b0, 16'h0000, 1'b1, 16'h0002, "status_reset");
    set_vec(1,  2'd2, 1'b0, 16'h0000, 1'b1, 16'd434,  "clkdiv_reset");
    set_vec(2,  2'd3, 1'b0, 16'h0000, 1'b1, 16'h0000, "rsvd_read");
    set_vec(3,  2'd0, 1'b0, 16'h0000, 1'b1, 16'h0000, "txdata_read");
    set_vec(4,  2'd3, 1'b1, 16'hBEEF, 1'b0, 16'h0000, "rsvd_write");
    set_vec(5,  2'd2, 1'b0, 16'h0000, 1'b1, 16'd434,  "clkdiv_after_rsvd");
    set_vec(6,  2'd2, 1'b1, 16'h0004, 1'b0, 16'h0000, "clkdiv_write");
    set_vec(7,  2'd2, 1'b0, 16'h0000, 1'b1, 16'h0004, "clkdiv_readback");
    set_vec(8,  2'd1, 1'b0, 16'h0000, 1'b1, 16'h0002, "status_no_push");
    set_vec(9,  2'd1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, "status_write");
    set_vec(10, 2'd1, 1'b0, 16'h0000, 1'b1, 16'h0002, "status_after_write");

    bus.S_PADDR = '0; bus.S_PWRITE = 1'b0; bus.S_PSELx = 1'b0;
    bus.S_PENABLE = 1'b0; bus.S_PWDATA = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {63'd0, tx_wire}, 64'd1);
    check("reset_pready", {63'd0, bus.S_PREADY}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      apb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd);
      if (vecs[i].chk) check(vecs[i].name, {48'd0, rd}, {48'd0, vecs[i].exp});
    end

    // Select low with enable high: no transfer, data forced to zero.
    bus.S_PADDR = 16'd2; bus.S_PENABLE = 1'b1;
    @(negedge clk);
    check("idle_prdata", {48'd0, bus.S_PRDATA}, 64'd0);
    check("idle_pready", {63'd0, bus.S_PREADY}, 64'd0);
    @(posedge clk); #1;
    bus.S_PENABLE = 1'b0;

    // Single 0x55 frame at div 4 with a busy poll during the start bit.
    mon_div = 4;
    mon_en  = 1'b1;
    push_byte(8'h55, 1'b1);
    check("tx_before_pop", {63'd0, tx_wire}, 64'd1);
    cap = '0;
    fork
      begin
        apb_xfer(2'd1, 1'b0, 16'd0, rd);
        check("status_busy", {48'd0, rd}, 64'h0006);
      end
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        cap[k] = tx_wire;
      end
    join
    expw = '0;
    for (int k = 0; k < 40; k++) expw[k] = frame_level(8'h55, 4, k);
    check("wave_55", cap, expw);
    @(posedge clk); #1;
    reg_read(2'd1, 16'h0002, "status_idle_after_55");

    // Back-to-back frames at div 2: no idle gap between stop and next start.
    reg_write(2'd2, 16'd2);
    mon_div = 2;
    push_byte(8'hA3, 1'b1);
    cap = '0;
    fork
      push_byte(8'h0F, 1'b1);
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        cap[k] = tx_wire;
      end
    join
    expw = '0;
    for (int k = 0; k < 20; k++) expw[k] = frame_level(8'hA3, 2, k);
    for (int k = 20; k < 40; k++) expw[k] = frame_level(8'h0F, 2, k - 20);
    check("wave_a3_0f", cap, expw);
    @(posedge clk); #1;
    reg_read(2'd1, 16'h0002, "status_idle_after_pair");
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    // Overflow: serializer stalled on a huge divisor, ten pushes into eight slots.
    mon_en = 1'b0;
    reg_write(2'd2, 16'hFFFF);
    for (int i = 0; i < 10; i++) push_byte(8'(i + 16), 1'b0);
    check("tx_long_start", {63'd0, tx_wire}, 64'd0);
    reg_read(2'd1, 16'h080D, "status_full_ovf");
    reg_write(2'd1, 16'h0000);
    reg_read(2'd1, 16'h0805, "status_ovf_cleared");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reg_read(2'd1, 16'h0002, "status_after_reset");
    reg_read(2'd2, 16'd434, "clkdiv_after_reset");

    // Reset in the middle of the data bits of a 0x00 frame.
    reg_write(2'd2, 16'd4);
    push_byte(8'h00, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("tx_in_data", {63'd0, tx_wire}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("tx_async_reset", {63'd0, tx_wire}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reg_read(2'd1, 16'h0002, "status_after_midframe_reset");
    all_high = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_wire !== 1'b1) all_high = 1'b0;
    end
    check("tx_quiet_after_reset", {63'd0, all_high}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
